// File: rtl/inert_ctrl.sv
// Sequences power-on configuration of a yaw-rate sensor over an SPI master,
// then reads the 16-bit yaw rate (low byte, then high byte) on each data-ready INT.
module inert_ctrl #(
    parameter int          POR_W     = 16,
    parameter logic [15:0] CFG_INT   = 16'h0D02,
    parameter logic [15:0] CFG_GYRO  = 16'h1160,
    parameter logic [15:0] CFG_ROUND = 16'h1440
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        cfg_done
);

    localparam logic [15:0] CMD_RD_L = 16'hA600;
    localparam logic [15:0] CMD_RD_H = 16'hA700;

    typedef enum logic [2:0] {
        POR_WAIT,
        CFG1,
        CFG2,
        CFG3,
        WAIT_INT,
        RD_L,
        RD_H
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [POR_W-1:0]  timer;
    logic              int_ff1;
    logic              int_ff2;
    logic [7:0]        yaw_l;
    logic              issue;
    logic [15:0]       cmd_nxt;
    logic              latch_l;
    logic              latch_h;
    logic              set_cfg;
    logic              xfer_done;
    logic              unused_rd_hi;

    assign unused_rd_hi = &{1'b0, rd_data[15:8]};

    // A done coinciding with our own wrt belongs to no transaction we started.
    assign xfer_done = done && !wrt;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        cmd_nxt   = cmd;
        latch_l   = 1'b0;
        latch_h   = 1'b0;
        set_cfg   = 1'b0;
        case (state)
            POR_WAIT: begin
                if (&timer) begin
                    state_nxt = CFG1;
                    issue     = 1'b1;
                    cmd_nxt   = CFG_INT;
                end
            end
            CFG1: begin
                if (xfer_done) begin
                    state_nxt = CFG2;
                    issue     = 1'b1;
                    cmd_nxt   = CFG_GYRO;
                end
            end
            CFG2: begin
                if (xfer_done) begin
                    state_nxt = CFG3;
                    issue     = 1'b1;
                    cmd_nxt   = CFG_ROUND;
                end
            end
            CFG3: begin
                if (xfer_done) begin
                    state_nxt = WAIT_INT;
                    set_cfg   = 1'b1;
                end
            end
            WAIT_INT: begin
                if (int_ff2) begin
                    state_nxt = RD_L;
                    issue     = 1'b1;
                    cmd_nxt   = CMD_RD_L;
                end
            end
            RD_L: begin
                if (xfer_done) begin
                    state_nxt = RD_H;
                    issue     = 1'b1;
                    cmd_nxt   = CMD_RD_H;
                    latch_l   = 1'b1;
                end
            end
            RD_H: begin
                if (xfer_done) begin
                    state_nxt = WAIT_INT;
                    latch_h   = 1'b1;
                end
            end
            default: state_nxt = POR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= POR_WAIT;
            timer    <= '0;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
            yaw_l    <= 8'h00;
            yaw_rt   <= 16'h0000;
            vld      <= 1'b0;
            cfg_done <= 1'b0;
            int_ff1  <= 1'b0;
            int_ff2  <= 1'b0;
        end else begin
            state   <= state_nxt;
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            if (state == POR_WAIT)
                timer <= timer + POR_W'(1);
            wrt <= issue;
            cmd <= cmd_nxt;
            if (latch_l)
                yaw_l <= rd_data[7:0];
            if (latch_h)
                yaw_rt <= {rd_data[7:0], yaw_l};
            vld <= latch_h;
            if (set_cfg)
                cfg_done <= 1'b1;
        end
    end

endmodule
